// File: rtl/pe_array_feeder.sv
// Operand feeder for an X-by-Y systolic PE array: accepts k-slices and skews them onto the array edges.
// Optional stall counter is enabled by defining FEEDER_STALL_CNT_EN.
module pe_array_feeder #(
   parameter int X      = 4,
   parameter int Y      = 4,
   parameter int L      = 4,
   parameter int RSA_DW = 16
) (
   input  logic                      clk,
   input  logic                      sys_rst,
   input  logic                      start,
   input  logic [$clog2(L+1)-1:0]    k_len,
   input  logic [1:0]                mode_in,
   input  logic                      op_val,
   output logic                      op_rdy,
   input  logic [X*RSA_DW-1:0]       op_A,
   input  logic [Y*RSA_DW-1:0]       op_B,
   output logic [1:0]                PE_mode,
   output logic [X*RSA_DW-1:0]       A_data,
   output logic [Y*RSA_DW-1:0]       B_data,
   output logic [Y-1:0]              new_cal_en,
   output logic [Y-1:0]              new_cal_done,
   output logic                      busy,
   output logic                      done,
   output logic [15:0]               stall_cnt
);

   localparam int KW = $clog2(L+1);
   localparam int M  = (X > Y) ? X : Y;
   localparam int DW = $clog2(M+1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]    state;
   logic [KW-1:0] k_len_q;
   logic [KW-1:0] beat_cnt;
   logic [DW-1:0] drain_cnt;
   logic          k_len_ok;
   logic          job_start;
   logic          xfer;
   logic          last_beat;

   assign k_len_ok  = (k_len != '0) && (k_len <= KW'(L));
   assign job_start = (state == S_IDLE) && start && k_len_ok;
   assign op_rdy    = (state == S_LOAD);
   assign busy      = (state != S_IDLE);
   assign xfer      = op_rdy && op_val;
   assign last_beat = xfer && (beat_cnt == k_len_q - KW'(1));

   // DRAIN lasts until the deepest lane has emptied; done fires in its final cycle
   always_ff @(posedge clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state     <= S_IDLE;
         k_len_q   <= '0;
         beat_cnt  <= '0;
         drain_cnt <= '0;
         PE_mode   <= 2'b00;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (job_start) begin
                  k_len_q  <= k_len;
                  PE_mode  <= mode_in;
                  beat_cnt <= '0;
                  state    <= S_LOAD;
               end else if (start) begin
                  done <= 1'b1;
               end
            end
            S_LOAD: begin
               if (xfer) begin
                  if (last_beat) begin
                     state     <= S_DRAIN;
                     drain_cnt <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + KW'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (drain_cnt == DW'(M-1)) done <= 1'b1;
               if (drain_cnt == DW'(M)) state <= S_IDLE;
               else                     drain_cnt <= drain_cnt + DW'(1);
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Row i is delayed by i+1 registers; non-transfer cycles push zero bubbles
   for (genvar i = 0; i < X; i++) begin : g_row
      logic [RSA_DW-1:0] a_sr [0:i];
      always_ff @(posedge clk or negedge sys_rst) begin
         if (!sys_rst) begin
            for (int s = 0; s <= i; s++) a_sr[s] <= '0;
         end else begin
            a_sr[0] <= xfer ? op_A[i*RSA_DW +: RSA_DW] : '0;
            for (int s = 1; s <= i; s++) a_sr[s] <= a_sr[s-1];
         end
      end
      assign A_data[i*RSA_DW +: RSA_DW] = a_sr[i];
   end

   for (genvar j = 0; j < Y; j++) begin : g_col
      logic [RSA_DW-1:0] b_sr  [0:j];
      logic              en_sr [0:j];
      logic              dn_sr [0:j];
      always_ff @(posedge clk or negedge sys_rst) begin
         if (!sys_rst) begin
            for (int s = 0; s <= j; s++) begin
               b_sr[s]  <= '0;
               en_sr[s] <= 1'b0;
               dn_sr[s] <= 1'b0;
            end
         end else begin
            b_sr[0]  <= xfer ? op_B[j*RSA_DW +: RSA_DW] : '0;
            en_sr[0] <= xfer;
            dn_sr[0] <= last_beat;
            for (int s = 1; s <= j; s++) begin
               b_sr[s]  <= b_sr[s-1];
               en_sr[s] <= en_sr[s-1];
               dn_sr[s] <= dn_sr[s-1];
            end
         end
      end
      assign B_data[j*RSA_DW +: RSA_DW] = b_sr[j];
      assign new_cal_en[j]              = en_sr[j];
      assign new_cal_done[j]            = dn_sr[j];
   end

`ifdef FEEDER_STALL_CNT_EN
   logic [15:0] stall_q;

   // Counts LOAD cycles starved of operands for the current job, saturating
   always_ff @(posedge clk or negedge sys_rst) begin
      if (!sys_rst) begin
         stall_q <= '0;
      end else if (job_start) begin
         stall_q <= '0;
      end else if ((state == S_LOAD) && !op_val && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end
   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_array_feeder.sv
// Directed self-checking bench for pe_array_feeder (X=Y=L=4, RSA_DW=16).
module tb_pe_array_feeder;

   logic        clk = 1'b0;
   logic        sys_rst;
   logic        start;
   logic [2:0]  k_len;
   logic [1:0]  mode_in;
   logic        op_val;
   logic        op_rdy;
   logic [63:0] op_A;
   logic [63:0] op_B;
   logic [1:0]  PE_mode;
   logic [63:0] A_data;
   logic [63:0] B_data;
   logic [3:0]  new_cal_en;
   logic [3:0]  new_cal_done;
   logic        busy;
   logic        done;
   logic [15:0] stall_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   pe_array_feeder #(.X(4), .Y(4), .L(4), .RSA_DW(16)) dut (
      .clk          (clk),
      .sys_rst      (sys_rst),
      .start        (start),
      .k_len        (k_len),
      .mode_in      (mode_in),
      .op_val       (op_val),
      .op_rdy       (op_rdy),
      .op_A         (op_A),
      .op_B         (op_B),
      .PE_mode      (PE_mode),
      .A_data       (A_data),
      .B_data       (B_data),
      .new_cal_en   (new_cal_en),
      .new_cal_done (new_cal_done),
      .busy         (busy),
      .done         (done),
      .stall_cnt    (stall_cnt)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic [2:0] kl, input logic [1:0] md,
                                input logic val, input logic [63:0] a, input logic [63:0] b);
      start   = st;
      k_len   = kl;
      mode_in = md;
      op_val  = val;
      op_A    = a;
      op_B    = b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] exp_row;
      int          done_seen;

      applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 64'h0, 64'h0);
      sys_rst = 1'b0;
      #3;
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_op_rdy", op_rdy, 1'b0);
      checkOutput("rst_A", A_data, 64'h0);
      checkOutput("rst_en", new_cal_en, 4'h0);
      tick();
      tick();
      sys_rst = 1'b1;
      tick();

      // k_len=1 single beat, watch it walk diagonally across the edges
      applyStimulus(1'b1, 3'd1, 2'd2, 1'b0, 64'h0, 64'h0);
      tick();
      checkOutput("t1_op_rdy", op_rdy, 1'b1);
      checkOutput("t1_mode", PE_mode, 2'd2);
      applyStimulus(1'b0, 3'd0, 2'd0, 1'b1, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005);
      tick();
      applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 64'h0, 64'h0);
      checkOutput("t1_A_t1", A_data, 64'h0000_0000_0000_0001);
      checkOutput("t1_B_t1", B_data, 64'h0000_0000_0000_0005);
      checkOutput("t1_en_t1", new_cal_en, 4'b0001);
      checkOutput("t1_dn_t1", new_cal_done, 4'b0001);
      checkOutput("t1_rdy_t1", op_rdy, 1'b0);
      tick();
      checkOutput("t1_A_t2", A_data, 64'h0000_0000_0002_0000);
      checkOutput("t1_en_t2", new_cal_en, 4'b0010);
      tick();
      checkOutput("t1_A_t3", A_data, 64'h0000_0003_0000_0000);
      tick();
      checkOutput("t1_A_t4", A_data, 64'h0004_0000_0000_0000);
      checkOutput("t1_B_t4", B_data, 64'h0008_0000_0000_0000);
      checkOutput("t1_en_t4", new_cal_en, 4'b1000);
      checkOutput("t1_dn_t4", new_cal_done, 4'b1000);
      checkOutput("t1_done_t4", done, 1'b0);
      tick();
      checkOutput("t1_done_t5", done, 1'b1);
      checkOutput("t1_A_t5", A_data, 64'h0);
      checkOutput("t1_en_t5", new_cal_en, 4'b0000);
      checkOutput("t1_busy_t5", busy, 1'b1);
      tick();
      checkOutput("t1_done_t6", done, 1'b0);
      checkOutput("t1_busy_t6", busy, 1'b0);
      checkOutput("t1_stall", stall_cnt, 16'd0);

      // k_len=4 back-to-back beats
      applyStimulus(1'b1, 3'd4, 2'd1, 1'b0, 64'h0, 64'h0);
      tick();
      for (int c = 0; c < 10; c++) begin
         if (c < 4) applyStimulus(1'b0, 3'd0, 2'd0, 1'b1, {48'h0, 16'(c + 1)}, {16'(c + 9), 48'h0});
         else       applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 64'h0, 64'h0);
         tick();
         exp_row = (c + 1 <= 4) ? 16'(c + 1) : 16'h0;
         checkOutput($sformatf("t2_en0_n%0d", c + 1), new_cal_en[0], (c + 1 >= 1) && (c + 1 <= 4));
         checkOutput($sformatf("t2_dn0_n%0d", c + 1), new_cal_done[0], c + 1 == 4);
         checkOutput($sformatf("t2_en3_n%0d", c + 1), new_cal_en[3], (c + 1 >= 4) && (c + 1 <= 7));
         checkOutput($sformatf("t2_dn3_n%0d", c + 1), new_cal_done[3], c + 1 == 7);
         checkOutput($sformatf("t2_done_n%0d", c + 1), done, c + 1 == 8);
         checkOutput($sformatf("t2_row0_n%0d", c + 1), A_data[15:0], exp_row);
      end
      checkOutput("t2_busy_end", busy, 1'b0);

      // k_len=2 with a one-cycle operand gap
      applyStimulus(1'b1, 3'd2, 2'd0, 1'b0, 64'h0, 64'h0);
      tick();
      for (int c = 0; c < 9; c++) begin
         if (c == 0)      applyStimulus(1'b0, 3'd0, 2'd0, 1'b1, 64'h0044_0033_0022_0011, 64'h00D4_00C3_00B2_00A1);
         else if (c == 2) applyStimulus(1'b0, 3'd0, 2'd0, 1'b1, 64'h0088_0077_0066_0055, 64'h00E8_00E7_00E6_00E5);
         else             applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 64'h0, 64'h0);
         tick();
         checkOutput($sformatf("t3_en0_n%0d", c + 1), new_cal_en[0], (c + 1 == 1) || (c + 1 == 3));
         checkOutput($sformatf("t3_en3_n%0d", c + 1), new_cal_en[3], (c + 1 == 4) || (c + 1 == 6));
         checkOutput($sformatf("t3_dn0_n%0d", c + 1), new_cal_done[0], c + 1 == 3);
         checkOutput($sformatf("t3_dn3_n%0d", c + 1), new_cal_done[3], c + 1 == 6);
         checkOutput($sformatf("t3_done_n%0d", c + 1), done, c + 1 == 7);
         exp_row = (c + 1 == 1) ? 16'h0011 : (c + 1 == 3) ? 16'h0055 : 16'h0;
         checkOutput($sformatf("t3_row0_n%0d", c + 1), A_data[15:0], exp_row);
         exp_row = (c + 1 == 4) ? 16'h0044 : (c + 1 == 6) ? 16'h0088 : 16'h0;
         checkOutput($sformatf("t3_row3_n%0d", c + 1), A_data[63:48], exp_row);
         exp_row = (c + 1 == 4) ? 16'h00D4 : (c + 1 == 6) ? 16'h00E8 : 16'h0;
         checkOutput($sformatf("t3_col3_n%0d", c + 1), B_data[63:48], exp_row);
      end
      checkOutput("t3_busy_end", busy, 1'b0);
`ifdef FEEDER_STALL_CNT_EN
      checkOutput("t3_stall", stall_cnt, 16'd1);
`else
      checkOutput("t3_stall", stall_cnt, 16'd0);
`endif

      // Out-of-range lengths are rejected with an immediate done
      applyStimulus(1'b1, 3'd0, 2'd1, 1'b0, 64'h0, 64'h0);
      checkOutput("t4_k0_rdy_req", op_rdy, 1'b0);
      tick();
      applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 64'h0, 64'h0);
      checkOutput("t4_k0_done", done, 1'b1);
      checkOutput("t4_k0_busy", busy, 1'b0);
      checkOutput("t4_k0_rdy", op_rdy, 1'b0);
      tick();
      checkOutput("t4_k0_done_off", done, 1'b0);
      applyStimulus(1'b1, 3'd5, 2'd1, 1'b0, 64'h0, 64'h0);
      tick();
      applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 64'h0, 64'h0);
      checkOutput("t4_k5_done", done, 1'b1);
      checkOutput("t4_k5_busy", busy, 1'b0);
      checkOutput("t4_k5_rdy", op_rdy, 1'b0);
      checkOutput("t4_k5_mode", PE_mode, 2'd0);
      tick();
      checkOutput("t4_k5_done_off", done, 1'b0);
      checkOutput("t4_k5_rdy2", op_rdy, 1'b0);

      // Reset in the middle of LOAD
      applyStimulus(1'b1, 3'd3, 2'd3, 1'b0, 64'h0, 64'h0);
      tick();
      applyStimulus(1'b0, 3'd0, 2'd0, 1'b1, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005);
      tick();
      checkOutput("t5_pre_A", A_data, 64'h0000_0000_0000_0001);
      checkOutput("t5_pre_busy", busy, 1'b1);
      #2;
      sys_rst = 1'b0;
      #1;
      checkOutput("t5_A", A_data, 64'h0);
      checkOutput("t5_B", B_data, 64'h0);
      checkOutput("t5_en", new_cal_en, 4'h0);
      checkOutput("t5_dn", new_cal_done, 4'h0);
      checkOutput("t5_rdy", op_rdy, 1'b0);
      checkOutput("t5_busy", busy, 1'b0);
      checkOutput("t5_done", done, 1'b0);
      checkOutput("t5_mode", PE_mode, 2'd0);
      checkOutput("t5_stall", stall_cnt, 16'd0);
      applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 64'h0, 64'h0);
      tick();
      sys_rst = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         checkOutput($sformatf("t5_post_n%0d", c), {busy, done, op_rdy}, 3'b000);
      end

      // start held during DRAIN is ignored; the job after done is accepted
      applyStimulus(1'b1, 3'd1, 2'd1, 1'b0, 64'h0, 64'h0);
      tick();
      applyStimulus(1'b0, 3'd0, 2'd0, 1'b1, 64'h0000_0000_0000_0007, 64'h0000_0000_0000_0009);
      tick();
      applyStimulus(1'b1, 3'd2, 2'd3, 1'b0, 64'h0, 64'h0);
      checkOutput("t6_busy_n1", busy, 1'b1);
      checkOutput("t6_rdy_n1", op_rdy, 1'b0);
      for (int n = 2; n <= 5; n++) begin
         tick();
         checkOutput($sformatf("t6_rdy_n%0d", n), op_rdy, 1'b0);
         checkOutput($sformatf("t6_mode_n%0d", n), PE_mode, 2'd1);
         checkOutput($sformatf("t6_done_n%0d", n), done, n == 5);
      end
      tick();
      checkOutput("t6_busy_n6", busy, 1'b0);
      checkOutput("t6_rdy_n6", op_rdy, 1'b0);
      tick();
      checkOutput("t6_rdy_n7", op_rdy, 1'b1);
      checkOutput("t6_mode_n7", PE_mode, 2'd3);
      done_seen = 0;
      for (int c = 0; c < 10; c++) begin
         if (c < 2) applyStimulus(1'b0, 3'd0, 2'd0, 1'b1, 64'h1, 64'h2);
         else       applyStimulus(1'b0, 3'd0, 2'd0, 1'b0, 64'h0, 64'h0);
         tick();
         if (done) done_seen++;
      end
      checkOutput("t6_second_done", done_seen, 1);
      checkOutput("t6_busy_end", busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
